// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline sequencer and the core: stall/redirect/memory inputs, stage enables, flushes, fault, perf counters.
// master = the sequencing controller, slave = the pipeline datapath and its hazard/memory sources.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             hazard_stall;
  logic             redirect;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             fault;
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;
  logic [CNT_W-1:0] perf_mem_cnt;

  modport master (
    input  hazard_stall, redirect, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, mem_wb_flush, fault,
    output perf_stall_cnt, perf_flush_cnt, perf_mem_cnt
  );

  modport slave (
    output hazard_stall, redirect, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, mem_wb_flush, fault,
    input  perf_stall_cnt, perf_flush_cnt, perf_mem_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges memory freeze, hazard stall and redirect into stage enables/flushes; zero-latency response.
// Memory busy freezes the front stages (backpressure) with a bounded wait, sticky FAULT on timeout; perf counters under PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  ctl
);

  localparam int                WC_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]   TIMEOUT = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
  typedef enum logic [2:0] {P_HALT, P_MEM, P_STALL, P_REDIR, P_RUN} prio_t;

  state_t          state_q;
  logic [WC_W-1:0] wait_cnt_q;
  logic            fault_q;
  logic            mem_busy;
  prio_t           prio;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;

  assign mem_busy = ctl.dmem_req & ~ctl.dmem_ready;

  always_comb begin
    prio = P_RUN;
    if (rst || state_q == FAULT)  prio = P_HALT;
    else if (mem_busy)            prio = P_MEM;
    else if (ctl.hazard_stall)    prio = P_STALL;
    else if (ctl.redirect)        prio = P_REDIR;
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    case (prio)
      P_HALT: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end
      // MEM/WB keeps clocking so the stalled access does not write back twice.
      P_MEM: begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_flush = 1'b1;
      end
      P_STALL: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
      P_REDIR: if_id_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_busy) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == TIMEOUT) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end
        default: begin
          state_q <= FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, mem_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d, flush_cnt_d, mem_cnt_d;

  // Only P_MEM/P_STALL/P_REDIR count, so FAULT and reset cycles hold naturally.
  assign stall_cnt_d = stall_cnt_q + CNT_W'(prio == P_STALL);
  assign flush_cnt_d = flush_cnt_q + CNT_W'(prio == P_REDIR);
  assign mem_cnt_d   = mem_cnt_q   + CNT_W'(prio == P_MEM);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_cnt_q   <= mem_cnt_d;
    end
  end

  assign ctl.perf_stall_cnt = stall_cnt_q;
  assign ctl.perf_flush_cnt = flush_cnt_q;
  assign ctl.perf_mem_cnt   = mem_cnt_q;
`else
  assign ctl.perf_stall_cnt = {CNT_W{1'b0}};
  assign ctl.perf_flush_cnt = {CNT_W{1'b0}};
  assign ctl.perf_mem_cnt   = {CNT_W{1'b0}};
`endif

  assign ctl.pc_en        = pc_en;
  assign ctl.if_id_en     = if_id_en;
  assign ctl.id_ex_en     = id_ex_en;
  assign ctl.ex_mem_en    = ex_mem_en;
  assign ctl.mem_wb_en    = mem_wb_en;
  assign ctl.if_id_flush  = if_id_flush;
  assign ctl.id_ex_flush  = id_ex_flush;
  assign ctl.mem_wb_flush = mem_wb_flush;
  assign ctl.fault        = fault_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Two controllers (MEM_TIMEOUT 4 and 16) share one stimulus stream and are checked every cycle
// against a consecutive-busy-count model, plus literal expectations for the directed scenarios.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, hz = 1'b0, rd = 1'b0, req = 1'b0, rdy = 1'b0;

`ifdef PIPE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipe_ctrl_if #(.CNT_W(32)) if_a ();
  pipe_ctrl_if #(.CNT_W(32)) if_b ();

  assign if_a.hazard_stall = hz;
  assign if_a.redirect     = rd;
  assign if_a.dmem_req     = req;
  assign if_a.dmem_ready   = rdy;
  assign if_b.hazard_stall = hz;
  assign if_b.redirect     = rd;
  assign if_b.dmem_req     = req;
  assign if_b.dmem_ready   = rdy;

  pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .ctl(if_a));
  pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .ctl(if_b));

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_flush}
  logic [7:0]  dvec [2];
  logic        dflt [2];
  logic [31:0] dst [2], dfl [2], dme [2];

  assign dvec[0] = {if_a.pc_en, if_a.if_id_en, if_a.id_ex_en, if_a.ex_mem_en, if_a.mem_wb_en,
                    if_a.if_id_flush, if_a.id_ex_flush, if_a.mem_wb_flush};
  assign dvec[1] = {if_b.pc_en, if_b.if_id_en, if_b.id_ex_en, if_b.ex_mem_en, if_b.mem_wb_en,
                    if_b.if_id_flush, if_b.id_ex_flush, if_b.mem_wb_flush};
  assign dflt[0] = if_a.fault;
  assign dflt[1] = if_b.fault;
  assign dst[0]  = if_a.perf_stall_cnt;
  assign dst[1]  = if_b.perf_stall_cnt;
  assign dfl[0]  = if_a.perf_flush_cnt;
  assign dfl[1]  = if_b.perf_flush_cnt;
  assign dme[0]  = if_a.perf_mem_cnt;
  assign dme[1]  = if_b.perf_mem_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: fault after MEM_TIMEOUT+1 consecutive busy cycles.
  int          mto [2] = '{4, 16};
  bit          mflt [2];
  int          mrun [2];
  bit [31:0]   ms [2], mf [2], mm [2];
  bit          armed = 1'b0;

  function automatic int prio_of(input int k);
    if (rst || mflt[k])   return 1;
    if (req && !rdy)      return 2;
    if (hz)               return 3;
    if (rd)               return 4;
    return 5;
  endfunction

  function automatic logic [7:0] exp_vec(input int p);
    case (p)
      1:       return 8'b00000_001;
      2:       return 8'b00001_001;
      3:       return 8'b00111_010;
      4:       return 8'b11111_100;
      default: return 8'b11111_000;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int p;
      p = prio_of(k);
      if (armed) begin
        chk($sformatf("vec%0d", k), 32'(dvec[k]), 32'(exp_vec(p)));
        chk($sformatf("fault%0d", k), 32'(dflt[k]), 32'(mflt[k]));
        chk($sformatf("stall_cnt%0d", k), dst[k], PERF ? ms[k] : 32'd0);
        chk($sformatf("flush_cnt%0d", k), dfl[k], PERF ? mf[k] : 32'd0);
        chk($sformatf("mem_cnt%0d", k), dme[k], PERF ? mm[k] : 32'd0);
      end
      if (rst) begin
        mflt[k] = 1'b0;
        mrun[k] = 0;
        ms[k] = 0;
        mf[k] = 0;
        mm[k] = 0;
      end else if (!mflt[k]) begin
        if (p == 2) mm[k]++;
        if (p == 3) ms[k]++;
        if (p == 4) mf[k]++;
        if (req && !rdy) begin
          mrun[k]++;
          if (mrun[k] == mto[k] + 1) mflt[k] = 1'b1;
        end else begin
          mrun[k] = 0;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic step(input bit r, input bit h, input bit d, input bit q, input bit y);
    @(posedge clk);
    #1;
    rst = r; hz = h; rd = d; req = q; rdy = y;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Idle after reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("idle_vec", 32'(dvec[1]), 32'hF8);
    chk("idle_fault", 32'(dflt[1]), 32'd0);
    chk("idle_cnt", dst[1] | dfl[1] | dme[1], 32'd0);

    // Hazard stall masks concurrent redirect
    step(0, 1, 1, 0, 0);
    chk("hz_rd_vec", 32'(dvec[1]), 32'h3A);
    step(0, 0, 0, 0, 0);
    chk("hz_stall_cnt", dst[1], PERF ? 32'd1 : 32'd0);
    chk("hz_flush_cnt", dfl[1], 32'd0);

    // Three-cycle memory wait
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      chk("mem_freeze_vec", 32'(dvec[1]), 32'h09);
    end
    step(0, 0, 0, 1, 1);
    chk("mem_done_vec", 32'(dvec[1]), 32'hF8);
    step(0, 0, 0, 0, 0);
    chk("mem_cnt3", dme[1], PERF ? 32'd3 : 32'd0);
    chk("mem_nofault", 32'(dflt[1]), 32'd0);

    // Timeout on the MEM_TIMEOUT=4 instance
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("to4_fault", 32'(dflt[0]), 32'd1);
    chk("to4_vec", 32'(dvec[0]), 32'h01);
    chk("to16_alive", 32'(dvec[1]), 32'hF8);
    step(0, 0, 0, 0, 0);
    chk("to4_sticky", 32'(dflt[0]), 32'd1);
    step(1, 0, 0, 0, 0);
    chk("to4_rst_vec", 32'(dvec[0]), 32'h01);
    step(0, 0, 0, 0, 0);
    chk("to4_cleared", 32'(dflt[0]), 32'd0);
    chk("to4_cleared_vec", 32'(dvec[0]), 32'hF8);

    // Ready in the last allowed cycle, MEM_TIMEOUT=4
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("to4_edge_nofault", 32'(dflt[0]), 32'd0);

    // MEM_TIMEOUT=16: 17 busy cycles fault, 16 then ready does not
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("to16_fault", 32'(dflt[1]), 32'd1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("to16_edge_nofault", 32'(dflt[1]), 32'd0);

    // Memory freeze wins over hazard and redirect
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    chk("busy_hz_vec", 32'(dvec[1]), 32'h09);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 1);
    step(0, 1, 0, 0, 0);
    chk("after_busy_hz_vec", 32'(dvec[1]), 32'h3A);

    // Randomized segments with varying memory latency bias
    step(1, 0, 0, 0, 0);
    for (int s = 0; s < 200; s++) begin
      int len, rdy_pct, req_pct;
      len     = $urandom_range(24, 1);
      rdy_pct = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(100, 20);
      req_pct = $urandom_range(90, 10);
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(63, 0) == 0),
             ($urandom_range(99, 0) < 25),
             ($urandom_range(99, 0) < 25),
             ($urandom_range(99, 0) < req_pct),
             ($urandom_range(99, 0) < rdy_pct));
      end
    end
    step(0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencing controller for the five-stage core. It merges the load-use/branch stall request from hazard detection, the ID-stage control-flow redirect and the data-memory handshake into one consistent set of per-stage enable and flush signals. A wait counter bounds data-memory latency and parks the core in a sticky fault state on timeout. Sits beside the hazard detector and drives the PC register plus the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- MEM_TIMEOUT, 16, consecutive data-memory busy cycles tolerated before fault; legal range 1..255.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- hazard_stall  input  1  stall request from hazard detection (load-use, branch/jalr operand dependency).
- redirect  input  1  taken branch/jump resolved in ID; wrong-path instruction sits in IF.
- dmem_req  input  1  EX/MEM holds a load or store this cycle.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_en  output  1  PC register load enable.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  pipeline register load enables.
- if_id_flush, id_ex_flush, mem_wb_flush  output  1 each  load a bubble (NOP, all control zero); flush overrides enable.
- fault  output  1  sticky memory-timeout indicator.
- perf_stall_cnt, perf_flush_cnt, perf_mem_cnt  output  CNT_W each  performance counters.

## Operation
- mem_busy = dmem_req & ~dmem_ready.
- FSM states: RUN, MEM_WAIT, FAULT. Internal wait_cnt, width $clog2(MEM_TIMEOUT+1).
- Stage outputs are combinational from state and inputs, evaluated in strict priority:
  1. rst high or state FAULT: all *_en = 0; if_id_flush = id_ex_flush = 0; mem_wb_flush = 1.
  2. mem_busy (RUN or MEM_WAIT): pc_en, if_id_en, id_ex_en and ex_mem_en = 0; mem_wb_en = 1, mem_wb_flush = 1. hazard_stall and redirect are ignored and re-evaluated once the freeze ends, because the ID contents are held.
  3. hazard_stall: pc_en = if_id_en = 0; id_ex_flush = 1; id_ex_en, ex_mem_en and mem_wb_en = 1. redirect is masked, since the stalled instruction is the branch itself.
  4. redirect: if_id_flush = 1; all enables 1.
  5. Otherwise: all enables 1, all flushes 0.
- Transitions:
  - RUN to MEM_WAIT on mem_busy; wait_cnt <= 1.
  - MEM_WAIT stays while mem_busy and wait_cnt < MEM_TIMEOUT; wait_cnt increments.
  - MEM_WAIT to RUN when ~mem_busy; wait_cnt <= 0.
  - MEM_WAIT to FAULT when mem_busy and wait_cnt == MEM_TIMEOUT.
  - FAULT is absorbing until rst.
- fault = (state == FAULT), registered.
- Reset: state RUN, wait_cnt 0, fault 0, all counters 0.

## Timing
- Stall and flush response is in the same cycle as the request (zero latency). Enables take effect at the next rising edge.
- dmem_ready arriving in the same cycle as dmem_req means no freeze.
- Timeout: the core is frozen for MEM_TIMEOUT+1 consecutive busy cycles, and fault rises on the following edge. With MEM_TIMEOUT=16, fault first reads 1 on cycle 17 after the first busy cycle.
- dmem_ready arriving in the last allowed cycle (wait_cnt == MEM_TIMEOUT, ready = 1) returns the FSM to RUN with no fault.
- rst asserted mid-wait or in FAULT: next edge gives RUN and fault = 0; outputs follow priority 1 while rst is high.
- Back-to-back memory ops: MEM_WAIT to RUN then immediately to MEM_WAIT again, with wait_cnt restarting at 1.

## Configuration
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments on every cycle where priority 3 applies.
  - perf_flush_cnt increments on every cycle where priority 4 applies.
  - perf_mem_cnt increments on every cycle where priority 2 applies.
  - Counters wrap modulo 2^CNT_W, hold in FAULT and clear on rst.
- Undefined: all perf_* outputs tied to 0; no counter flops are synthesized.

## Test plan
- Idle after reset (no requests): all enables 1, all flushes 0, fault 0 and all counters 0 after rst drops.
- One-cycle hazard_stall with redirect = 1 in the same cycle: pc_en = 0, if_id_en = 0, id_ex_flush = 1, if_id_flush = 0; perf_stall_cnt = 1 and perf_flush_cnt = 0.
- dmem_req held with dmem_ready low for 3 cycles, then high: front stages frozen and mem_wb_flush = 1 for exactly 3 cycles; state returns to RUN; perf_mem_cnt = 3; fault stays 0.
- MEM_TIMEOUT = 4 with dmem_ready never asserted: fault = 1 after 5 busy cycles; all enables stay 0 thereafter; ready going high later does not recover the core; rst clears fault in one cycle.
- Memory busy concurrent with hazard_stall and redirect: only the memory freeze pattern appears. When ready rises, the hazard stall pattern appears in the following cycle if hazard_stall is still asserted.
- Build without PIPE_CTRL_PERF_CNT_EN: repeat the scenario 3 stimulus; perf_* outputs read 0 throughout.
